// File: rtl/dest_pkg.sv
// Shared types for the destination-register tracker: destination-mode encoding
// and the per-stage pipeline entry.
package dest_pkg;

  // Entry address storage width; must be at least the tracker's ADDR_W.
  localparam int ENTRY_ADDR_W = 8;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } dst_sel_e;

  typedef struct packed {
    logic                    valid;
    logic                    we;
    logic [ENTRY_ADDR_W-1:0] addr;
  } stage_entry_t;

endpackage

// File: rtl/dest_sel_mux.sv
// Selects the destination register of the decoding instruction from its
// destination mode: rt, rd, the link register, or none (register 0).
module dest_sel_mux
  import dest_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  dst_sel_e          dst_sel,
  input  logic [ADDR_W-1:0] rt_field,
  input  logic [ADDR_W-1:0] rd_field,
  output logic [ADDR_W-1:0] dest_addr
);

  always_comb begin
    // NOTE: default first so every path assigns dest_addr and no latch is inferred.
    dest_addr = '0;
    case (dst_sel)
      DST_RT:   dest_addr = rt_field;
      DST_RD:   dest_addr = rd_field;
      DST_LINK: dest_addr = ADDR_W'(LINK_REG);
      default:  dest_addr = '0;
    endcase
  end

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks destination registers of in-flight instructions from issue to
// write-back, producing the write-back strobe plus hazard/forwarding selects.
module dest_reg_tracker
  import dest_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [1:0]        dst_sel,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rt_field,
  input  logic [ADDR_W-1:0] rd_field,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [STAGES-2:0] fwd_a,
  output logic [STAGES-2:0] fwd_b
);

  localparam int LAST = STAGES - 1;

  dst_sel_e     sel;
  logic         accept;
  stage_entry_t new_entry;
  stage_entry_t stage_q [STAGES];
  logic [STAGES-2:0] match_a;
  logic [STAGES-2:0] match_b;

  assign sel = dst_sel_e'(dst_sel);

  dest_sel_mux #(
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_dest_sel_mux (
    .dst_sel   (sel),
    .rt_field  (rt_field),
    .rd_field  (rd_field),
    .dest_addr (dest_addr)
  );

  // Flush beats issue; register 0 is never tracked as a write.
  assign accept = issue_valid && !stall && !flush;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = accept;
    new_entry.we    = accept && reg_write && (sel != DST_NONE) && (dest_addr != '0);
    new_entry.addr  = ENTRY_ADDR_W'(dest_addr);
  end

  // NOTE: the stage array is a handful of flops, not a RAM, so it is reset
  // (valid bits must clear); non-blocking assignments keep the shift ordered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= flush ? '0 : new_entry;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= flush ? '0 : stage_q[k-1];
    end
  end

  // The last stage is writing the register file this cycle (write-first), so
  // it never counts as a hazard.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < STAGES - 1; k++) begin
      match_a[k] = stage_q[k].valid && stage_q[k].we && (src_a != '0) &&
                   (stage_q[k].addr == ENTRY_ADDR_W'(src_a));
      match_b[k] = stage_q[k].valid && stage_q[k].we && (src_b != '0) &&
                   (stage_q[k].addr == ENTRY_ADDR_W'(src_b));
    end
  end

  // Isolate the lowest set bit: the youngest matching stage.
  assign fwd_a    = match_a & (~match_a + (STAGES-1)'(1));
  assign fwd_b    = match_b & (~match_b + (STAGES-1)'(1));
  assign hazard_a = |match_a;
  assign hazard_b = |match_b;

  assign wb_en   = stage_q[LAST].valid && stage_q[LAST].we;
  assign wb_addr = wb_en ? stage_q[LAST].addr[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed self-checking bench for dest_reg_tracker with STAGES=3.
module tb_dest_reg_tracker;
  import dest_pkg::*;

  localparam int ADDR_W = 5;
  localparam int STAGES = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [1:0]        dst_sel;
  logic              reg_write;
  logic [ADDR_W-1:0] rt_field, rd_field, src_a, src_b;
  logic              stall, flush;
  logic [ADDR_W-1:0] dest_addr, wb_addr;
  logic              wb_en, hazard_a, hazard_b;
  logic [STAGES-2:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  dest_reg_tracker #(.ADDR_W(ADDR_W), .STAGES(STAGES), .LINK_REG(31)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .dst_sel     (dst_sel),
    .reg_write   (reg_write),
    .rt_field    (rt_field),
    .rd_field    (rd_field),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .flush       (flush),
    .dest_addr   (dest_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs then change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input dst_sel_e sel, input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd);
    issue_valid = 1'b1;
    dst_sel     = sel;
    reg_write   = 1'b1;
    rt_field    = rt;
    rd_field    = rd;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    reg_write   = 1'b0;
    dst_sel     = DST_NONE;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; dst_sel = DST_NONE; reg_write = 1'b0;
    rt_field = '0; rd_field = '0; src_a = '0; src_b = '0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    src_a = 5'd5; src_b = 5'd9; #1;
    check("reset_wb_en",   wb_en,    0);
    check("reset_wb_addr", wb_addr,  0);
    check("reset_haz_a",   hazard_a, 0);
    check("reset_fwd_b",   fwd_b,    0);

    // R-type to rd=9
    issue(DST_RD, 5'd4, 5'd9); #1;
    check("rtype_dest", dest_addr, 9);
    tick();                                   // edge 0
    idle(); src_a = 5'd9; #1;
    check("rtype_e0_wb",  wb_en,    0);
    check("rtype_haz_a",  hazard_a, 1);
    check("rtype_fwd_a",  fwd_a,    2'b01);
    tick();                                   // edge 1
    check("rtype_e1_wb",  wb_en,    0);
    tick();                                   // edge 2
    check("rtype_e2_wb",  wb_en,    1);
    check("rtype_e2_adr", wb_addr,  9);
    check("rtype_e2_haz", hazard_a, 0);
    tick();                                   // edge 3
    check("rtype_e3_wb",  wb_en,    0);
    check("rtype_e3_adr", wb_addr,  0);

    // jal / none / rd=0
    dst_sel = DST_LINK; #1;
    check("jal_dest", dest_addr, 31);
    dst_sel = DST_NONE; rd_field = 5'd12; rt_field = 5'd13; #1;
    check("none_dest", dest_addr, 0);
    dst_sel = DST_RT; #1;
    check("rt_dest", dest_addr, 13);
    issue(DST_RD, 5'd3, 5'd0); src_a = '0; src_b = '0; #1;
    check("rd0_dest", dest_addr, 0);
    tick();
    idle(); #1;
    check("rd0_haz_a", hazard_a, 0);
    tick(); tick();
    check("rd0_wb", wb_en, 0);

    // load-use with a one-cycle stall
    issue(DST_RT, 5'd8, 5'd2);
    tick();
    issue(DST_RD, 5'd1, 5'd20); reg_write = 1'b1; src_a = 5'd8; stall = 1'b1; #1;
    check("lu_haz_a",  hazard_a, 1);
    check("lu_fwd_a0", fwd_a,    2'b01);
    tick();
    check("lu_fwd_a1", fwd_a,    2'b10);
    check("lu_haz_a1", hazard_a, 1);
    stall = 1'b0; idle();
    tick();
    check("lu_haz_wb", hazard_a, 0);
    check("lu_wb_en",  wb_en,    1);
    check("lu_wb_adr", wb_addr,  8);
    tick();
    check("lu_bubble_wb", wb_en, 0);
    tick(); tick();
    src_a = '0;

    // two writers to r5
    issue(DST_RT, 5'd5, 5'd0);
    tick();
    issue(DST_RT, 5'd5, 5'd0);
    tick();
    idle(); src_b = 5'd5; #1;
    check("ww_haz_b",  hazard_b, 1);
    check("ww_fwd_b0", fwd_b,    2'b01);
    tick();
    check("ww_fwd_b1", fwd_b,    2'b10);
    tick(); tick();
    src_b = '0;

    // flush with 3,6,7 in stages 0,1,2; concurrent issue of r12 must be dropped
    issue(DST_RD, 5'd0, 5'd7); tick();
    issue(DST_RD, 5'd0, 5'd6); tick();
    issue(DST_RD, 5'd0, 5'd3); tick();
    issue(DST_RD, 5'd0, 5'd12); flush = 1'b1; src_a = 5'd3; src_b = 5'd6; #1;
    check("fl_wb_en",  wb_en,    1);
    check("fl_wb_adr", wb_addr,  7);
    check("fl_haz_a",  hazard_a, 1);
    check("fl_haz_b",  hazard_b, 1);
    tick();
    flush = 1'b0; idle(); #1;
    check("fl_clr_a",  hazard_a, 0);
    check("fl_clr_b",  hazard_b, 0);
    check("fl_wb1",    wb_en,    0);
    tick();
    check("fl_wb2",    wb_en,    0);
    tick();
    check("fl_wb3",    wb_en,    0);
    check("fl_wb3adr", wb_addr,  0);

    // reset with a full pipeline; concurrent issue of r13 must be dropped
    issue(DST_RD, 5'd0, 5'd10); tick();
    issue(DST_RD, 5'd0, 5'd11); tick();
    issue(DST_RD, 5'd0, 5'd12); tick();
    issue(DST_RD, 5'd0, 5'd13); rst_n = 1'b0; src_a = 5'd11; src_b = 5'd12; #1;
    check("rs_pre_wb", wb_addr, 10);
    tick();
    rst_n = 1'b1; idle(); #1;
    check("rs_wb_en",  wb_en,    0);
    check("rs_wb_adr", wb_addr,  0);
    check("rs_haz_a",  hazard_a, 0);
    check("rs_haz_b",  hazard_b, 0);
    check("rs_fwd_a",  fwd_a,    0);
    tick();
    check("rs_wb_e2",  wb_en,    0);
    issue(DST_RD, 5'd0, 5'd14);
    tick();
    idle();
    tick();
    check("rs_new_e1", wb_en,    0);
    tick();
    check("rs_new_wb", wb_en,    1);
    check("rs_new_ad", wb_addr,  14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_reg_tracker.md
DEST_REG_TRACKER -- requirements
Module: dest_reg_tracker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter STAGES, default 3, range 2..8, giving the pipeline depth from issue to write-back.
REQ-003 The block SHALL have parameter LINK_REG, default 31, giving the link-register address used by jal-type writes.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 issue_valid  in  1  an instruction is presented this cycle.
REQ-007 dst_sel  in  2  destination mode: 00 RT, 01 RD, 10 LINK, 11 NONE.
REQ-008 reg_write  in  1  the instruction writes the register file.
REQ-009 rt_field, rd_field  in  ADDR_W each  instr[20:16] and instr[15:11].
REQ-010 src_a, src_b  in  ADDR_W each  source registers of the instruction being decoded.
REQ-011 stall  in  1  hold decode: no entry is accepted this cycle.
REQ-012 flush  in  1  squash all in-flight entries not yet in write-back.
REQ-013 dest_addr  out  ADDR_W  combinational destination of the current instruction.
REQ-014 wb_en, wb_addr  out  1, ADDR_W  registered write-back strobe and address.
REQ-015 hazard_a, hazard_b  out  1 each  source matches a pending write.
REQ-016 fwd_a, fwd_b  out  STAGES-1 each  one-hot youngest matching stage for forwarding.

Function
REQ-017 dest_addr SHALL be rt_field for RT, rd_field for RD, LINK_REG for LINK, and 0 for NONE.
REQ-018 An entry SHALL be accepted at a rising edge iff issue_valid=1, stall=0, flush=0 and rst_n=1.
REQ-019 An accepted entry's write flag SHALL be reg_write AND (dst_sel != NONE) AND (dest_addr != 0); register 0 is never tracked.
REQ-020 Stage k+1 SHALL load stage k every cycle; stage 0 SHALL load a bubble (valid=0) when no entry is accepted.
REQ-021 stall SHALL NOT freeze stages 1..STAGES-1; older entries keep advancing, so a bubble is inserted.
REQ-022 An entry accepted at edge t SHALL drive wb_en=1 and wb_addr=its destination during the cycle after edge t+STAGES-1.
REQ-023 wb_en SHALL be 0 and wb_addr SHALL be 0 whenever the last stage holds a bubble or a non-writing entry.
REQ-024 flush SHALL clear stages 0..STAGES-2 to bubbles at the next edge; the entry moving into the last stage at that edge is also cleared; the entry already in the last stage still completes its write-back.
REQ-025 flush together with stall or issue_valid: flush SHALL win and no entry is accepted.
REQ-026 hazard_a SHALL be 1 iff src_a != 0 and src_a equals the destination of any writing entry in stages 0..STAGES-2; hazard_b likewise for src_b.
REQ-027 The last stage SHALL be excluded from hazard detection, because the register file is write-first.
REQ-028 fwd_a bit k SHALL be set only for the youngest (lowest k) matching stage; fwd_a SHALL be all-zero when hazard_a=0; fwd_b likewise.
REQ-029 The hazard and fwd outputs SHALL be combinational from stage state and src inputs, independent of stall and issue_valid.

Reset
REQ-030 When rst_n=0 at a rising edge, every stage SHALL become a bubble, and wb_en, wb_addr, hazard_*, fwd_* SHALL be 0 from the following cycle.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries, including the one in the last stage; no write-back occurs in the cycle after reset.
REQ-032 Reset SHALL take priority over flush, stall and issue.

Structure
REQ-033 Package dest_pkg SHALL hold the dst_sel enumeration (DST_RT, DST_RD, DST_LINK, DST_NONE) and the stage-entry struct {valid, we, addr}.
REQ-034 Sub-module dest_sel_mux SHALL implement REQ-017 combinationally, parameterised by ADDR_W and LINK_REG.
REQ-035 Stage storage SHALL be an array of STAGES entries with no per-stage hand-written logic.

Verification (STAGES=3)
REQ-036 R-type: dst_sel=RD, rd=9, rt=4, reg_write=1 issued at edge 0 -> dest_addr=9 at once; wb_en=1, wb_addr=9 in the cycle after edge 2 only.
REQ-037 jal: dst_sel=LINK -> dest_addr=31; rd=0 with RD -> no wb_en, no hazard when src_a=0.
REQ-038 Load-use: lw to rt=8 issued; next cycle src_a=8 -> hazard_a=1, fwd_a=01; stall held for 1 cycle -> bubble inserted, fwd_a=10 in the following cycle.
REQ-039 Two writers to reg 5 in consecutive cycles; src_b=5 -> fwd_b selects stage 0 only.
REQ-040 flush while entries to regs 3, 6 and 7 sit in stages 0, 1 and 2 -> only reg 7 is written back; hazards clear next cycle.
REQ-041 rst_n=0 with a full pipeline -> all outputs 0 the next cycle; a fresh issue after release writes back after 3 edges.
